pc_sequencer: RTL

Program-counter sequencer for the MIPS core. It owns the PC register and runs instruction fetch over a request/acknowledge handshake with instruction memory. It presents each fetched word to decode and holds it until decode retires it. On retire it loads either the sequential PC+4 or the redirect target produced by the next-PC selector, which covers jump, jump-register and taken-branch results.

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 23 ++
 rtl/pc_align_check.sv | 9 +
 rtl/pc_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } pc_state_e;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the sequencer and imem.
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_align_check.sv
// Combinational detect of a redirect target that is not word aligned.
module pc_align_check (
  input  logic [1:0] i_low_bits,
  output logic       o_misaligned
);

  assign o_misaligned = |i_low_bits;

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch/hold sequencing for the MIPS core.
// Optional misaligned-redirect trap is built when PC_MISALIGN_TRAP_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  pc_sequencer_if.master        imem,
  input  logic [31:0]           jump_result,
  input  logic                  redirect,
  input  logic                  stall,
  input  logic                  retire,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           pc,
  output logic [31:0]           next_pc
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap,
  output logic [31:0]           trap_epc
`endif
);

  pc_state_e   r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_instr, w_instr_d;
  logic        r_valid, w_valid_d;
  logic        w_accept;
  logic [31:0] w_seq_pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic        r_trap, w_trap_d;
  logic [31:0] r_epc, w_epc_d;
  logic        w_misaligned;

  pc_align_check u_align_check (
    .i_low_bits   (jump_result[1:0]),
    .o_misaligned (w_misaligned)
  );
`else
  // Low target bits are dropped silently in this build.
  logic w_unused_low;
  assign w_unused_low = ^jump_result[1:0];
`endif

  assign w_seq_pc = r_pc + PC_STEP;
  assign w_accept = (r_state == StHold) && retire && !stall;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_valid_d = r_valid;
`ifdef PC_MISALIGN_TRAP_EN
    w_trap_d  = 1'b0;
    w_epc_d   = r_epc;
`endif
    unique case (r_state)
      StIdle: begin
        w_state_d = StFetch;
      end
      StFetch: begin
        if (imem.imem_ack) begin
          w_instr_d = imem.imem_rdata;
          w_valid_d = 1'b1;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (w_accept) begin
          w_valid_d = 1'b0;
          w_state_d = StFetch;
          w_pc_d    = redirect ? word_align(jump_result) : w_seq_pc;
`ifdef PC_MISALIGN_TRAP_EN
          if (redirect && w_misaligned) begin
            w_pc_d   = TRAP_VECTOR;
            w_epc_d  = jump_result;
            w_trap_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_valid <= w_valid_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_trap <= 1'b0;
      r_epc  <= 32'h0;
    end else begin
      r_trap <= w_trap_d;
      r_epc  <= w_epc_d;
    end
  end

  assign misalign_trap = r_trap;
  assign trap_epc      = r_epc;
`endif

  // Request is a decode of the state register, so reset clears it immediately.
  assign imem.imem_req  = (r_state == StFetch);
  assign imem.imem_addr = r_pc;
  assign instr_valid    = r_valid;
  assign instr          = r_instr;
  assign pc             = r_pc;
  assign next_pc        = w_seq_pc;

endmodule
